trace_buffer_reader: RTL

- Read side of the trigger capture buffer; the trigger block is the writer.
- After the trigger block signals a completed capture, this block reads all DEPTH stored 12-bit samples in address order from the buffer's synchronous read port.
- Each sample is converted to a screen Y coordinate and streamed to the display path over a valid/ready interface.
- While reading, it holds off the writer so a frame is never torn.

---
 rtl/osc_trace_pkg.sv | 30 +++
 rtl/trace_buffer_reader_if.sv | 26 ++
 rtl/trace_buffer_reader_skid_fifo.sv | 48 ++++
 rtl/trace_buffer_reader.sv | 99 +++++++++
 4 files changed

// File: rtl/osc_trace_pkg.sv
// Constants and types shared by the trigger capture buffer and its reader.
// Both sides of the buffer must agree on these values.
package osc_trace_pkg;
  localparam int DEPTH    = 256;
  localparam int ADDR_W   = 8;
  localparam int SAMPLE_W = 12;
  localparam int Y_W      = 9;
  localparam int SHIFT    = 3;
  localparam int Y_MAX    = 511;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} reader_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] x;
    logic [Y_W-1:0]    y;
    logic              first;
    logic              last;
  } trace_pt_t;

  typedef logic [Y_W:0] y_wide_t;

  // Larger samples are drawn higher up the screen; anything past the top clamps to row 0.
  function automatic logic [Y_W-1:0] sample_to_y(input logic [SAMPLE_W-1:0] sample);
    logic [SAMPLE_W-1:0] shifted;
    y_wide_t             diff;
    shifted = sample >> SHIFT;
    diff    = y_wide_t'(Y_MAX) - y_wide_t'(shifted);
    return diff[Y_W] ? '0 : diff[Y_W-1:0];
  endfunction
endpackage

// File: rtl/trace_buffer_reader_if.sv
// Reader-side bundle: trigger handshake, capture buffer read port and display stream.
interface trace_buffer_reader_if;
  import osc_trace_pkg::*;

  logic                capture_done;
  logic                buf_busy;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic [SAMPLE_W-1:0] rd_data;
  logic                out_valid;
  logic                out_ready;
  logic [ADDR_W-1:0]   out_x;
  logic [Y_W-1:0]      out_y;
  logic                out_first;
  logic                out_last;

  modport master (
    input  capture_done, rd_data, out_ready,
    output buf_busy, rd_en, rd_addr, out_valid, out_x, out_y, out_first, out_last
  );

  modport slave (
    output capture_done, rd_data, out_ready,
    input  buf_busy, rd_en, rd_addr, out_valid, out_x, out_y, out_first, out_last
  );
endinterface

// File: rtl/trace_buffer_reader_skid_fifo.sv
// Two-entry FIFO of trace points that absorbs the one-cycle buffer read latency
// so the display stream can run at one sample per clock under backpressure.
module trace_skid_fifo
  import osc_trace_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  trace_pt_t  push_pt,
  input  logic       pop,
  output trace_pt_t  head,
  output logic [1:0] count,
  output logic       empty
);
  trace_pt_t mem [2];
  logic      wr_ptr;
  logic      rd_ptr;
  logic      do_push;
  logic      do_pop;

  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_pt;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/trace_buffer_reader.sv
// Reads a completed capture out of the trace buffer in address order and streams
// screen coordinates to the display, holding off the writer until the frame is sent.
module trace_buffer_reader
  import osc_trace_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  trace_buffer_reader_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  reader_state_t     state;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              buf_busy_q;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_x;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              pop;
  logic [2:0]        slots_used;
  trace_pt_t         push_pt;
  trace_pt_t         head_pt;

  assign pop = !fifo_empty && bus.out_ready;

  // A pop in this cycle frees its slot for the read being issued now.
  assign slots_used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign bus.rd_en  = (state == READ) && (slots_used < 3'd2);

  assign bus.rd_addr   = rd_addr_q;
  assign bus.buf_busy  = buf_busy_q;
  assign bus.out_valid = !fifo_empty;
  assign bus.out_x     = head_pt.x;
  assign bus.out_y     = head_pt.y;
  assign bus.out_first = head_pt.first;
  assign bus.out_last  = head_pt.last;

  always_comb begin
    push_pt       = '0;
    push_pt.x     = inflight_x;
    push_pt.y     = sample_to_y(bus.rd_data);
    push_pt.first = (inflight_x == '0);
    push_pt.last  = (inflight_x == LAST_ADDR);
  end

  trace_skid_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (inflight),
    .push_pt (push_pt),
    .pop     (pop),
    .head    (head_pt),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  // Triggers arriving outside IDLE are dropped, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rd_addr_q  <= '0;
      buf_busy_q <= 1'b0;
      inflight   <= 1'b0;
      inflight_x <= '0;
    end else begin
      inflight <= bus.rd_en;
      if (bus.rd_en) begin
        inflight_x <= rd_addr_q;
      end
      case (state)
        IDLE: begin
          if (bus.capture_done) begin
            state      <= READ;
            rd_addr_q  <= '0;
            buf_busy_q <= 1'b1;
          end
        end
        READ: begin
          if (bus.rd_en) begin
            rd_addr_q <= rd_addr_q + 1'b1;
            if (rd_addr_q == LAST_ADDR) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!inflight && (fifo_count == {1'b0, pop})) begin
            state      <= IDLE;
            buf_busy_q <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          buf_busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
